// File: rtl/axi_lite_master.sv
// -----------------------------------------------------------------------------
// axi_lite_master
// Turns a simple command/response handshake into single AXI4-lite read or write
// transactions. Only one transaction is in flight at a time. Every output comes
// straight from a flop.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESETN : clock, asynchronous active-low reset
//   cmd_*                     : command in (valid/ready, write flag, addr, data, strobes)
//   rsp_*                     : response out (valid/ready, read data, BRESP/RRESP)
//   M_AXI_AW*/W*/B*           : AXI4-lite write address, write data, write response
//   M_AXI_AR*/R*              : AXI4-lite read address, read data
// -----------------------------------------------------------------------------
module axi_lite_master #(
  parameter int C_M_AXI_ADDR_WIDTH = 4
) (
  input  logic                          M_AXI_ACLK,
  input  logic                          M_AXI_ARESETN,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]                   cmd_wdata,
  input  logic [3:0]                    cmd_wstrb,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [31:0]                   rsp_rdata,
  output logic [1:0]                    rsp_resp,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic [2:0]                    M_AXI_AWPROT,
  output logic                          M_AXI_AWVALID,
  input  logic                          M_AXI_AWREADY,
  output logic [31:0]                   M_AXI_WDATA,
  output logic [3:0]                    M_AXI_WSTRB,
  output logic                          M_AXI_WVALID,
  input  logic                          M_AXI_WREADY,
  input  logic [1:0]                    M_AXI_BRESP,
  input  logic                          M_AXI_BVALID,
  output logic                          M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [2:0]                    M_AXI_ARPROT,
  output logic                          M_AXI_ARVALID,
  input  logic                          M_AXI_ARREADY,
  input  logic [31:0]                   M_AXI_RDATA,
  input  logic [1:0]                    M_AXI_RRESP,
  input  logic                          M_AXI_RVALID,
  output logic                          M_AXI_RREADY
);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE} state_t;

  state_t state, next_state;

  logic                          accept;
  logic                          cmd_ready_d, awvalid_d, wvalid_d, bready_d;
  logic                          arvalid_d, rready_d, rsp_valid_d;
  logic [C_M_AXI_ADDR_WIDTH-1:0] awaddr_d, araddr_d;
  logic [31:0]                   wdata_d, rsp_rdata_d;
  logic [3:0]                    wstrb_d;
  logic [1:0]                    rsp_resp_d;

  assign accept       = (state == IDLE) && cmd_valid && cmd_ready;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;

  // State and all registered outputs. Reset abandons any transaction in flight.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state         <= IDLE;
      cmd_ready     <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      rsp_valid     <= 1'b0;
      M_AXI_AWADDR  <= '0;
      M_AXI_ARADDR  <= '0;
      M_AXI_WDATA   <= '0;
      M_AXI_WSTRB   <= '0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
    end else begin
      state         <= next_state;
      cmd_ready     <= cmd_ready_d;
      M_AXI_AWVALID <= awvalid_d;
      M_AXI_WVALID  <= wvalid_d;
      M_AXI_BREADY  <= bready_d;
      M_AXI_ARVALID <= arvalid_d;
      M_AXI_RREADY  <= rready_d;
      rsp_valid     <= rsp_valid_d;
      M_AXI_AWADDR  <= awaddr_d;
      M_AXI_ARADDR  <= araddr_d;
      M_AXI_WDATA   <= wdata_d;
      M_AXI_WSTRB   <= wstrb_d;
      rsp_rdata     <= rsp_rdata_d;
      rsp_resp      <= rsp_resp_d;
    end
  end

  // Next state. A write channel counts as done once its VALID has dropped, or
  // when its handshake is being sampled on this edge; both must be done to leave WR_REQ.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if ((!M_AXI_AWVALID || M_AXI_AWREADY) && (!M_AXI_WVALID || M_AXI_WREADY))
                 next_state = WR_RESP;
      WR_RESP: if (M_AXI_BVALID && M_AXI_BREADY) next_state = DONE;
      RD_REQ:  if (M_AXI_ARVALID && M_AXI_ARREADY) next_state = RD_DATA;
      RD_DATA: if (M_AXI_RVALID && M_AXI_RREADY) next_state = DONE;
      DONE:    if (rsp_valid && rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the output flops. Everything holds unless an event below
  // changes it. cmd_ready follows the state being entered, so it rises on the
  // cycle after the response handshake.
  always_comb begin
    cmd_ready_d = (next_state == IDLE);
    awvalid_d   = M_AXI_AWVALID;
    wvalid_d    = M_AXI_WVALID;
    bready_d    = M_AXI_BREADY;
    arvalid_d   = M_AXI_ARVALID;
    rready_d    = M_AXI_RREADY;
    rsp_valid_d = rsp_valid;
    awaddr_d    = M_AXI_AWADDR;
    araddr_d    = M_AXI_ARADDR;
    wdata_d     = M_AXI_WDATA;
    wstrb_d     = M_AXI_WSTRB;
    rsp_rdata_d = rsp_rdata;
    rsp_resp_d  = rsp_resp;
    case (state)
      IDLE: begin
        if (accept) begin
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
          end
        end
      end
      WR_REQ: begin
        if (M_AXI_AWVALID && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (M_AXI_WVALID && M_AXI_WREADY) wvalid_d = 1'b0;
        // BREADY is held low until both request channels are done, so an early BVALID is left waiting.
        if (next_state == WR_RESP) bready_d = 1'b1;
      end
      WR_RESP: begin
        if (M_AXI_BVALID && M_AXI_BREADY) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = 32'h0;
          rsp_resp_d  = M_AXI_BRESP;
        end
      end
      RD_REQ: begin
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end
      end
      RD_DATA: begin
        if (M_AXI_RVALID && M_AXI_RREADY) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = M_AXI_RDATA;
          rsp_resp_d  = M_AXI_RRESP;
        end
      end
      DONE: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// -----------------------------------------------------------------------------
// tb_axi_lite_master
// Self-checking bench for axi_lite_master. A transaction-level model tracks
// which handshakes are pending and what response is owed. It checks every DUT
// output on each falling edge. The AXI slave and the command/response partners
// are driven from per-command delay settings, with random noise wherever the
// values are don't-care.
// -----------------------------------------------------------------------------
module tb_axi_lite_master;

  localparam int AW = 4;

  typedef struct {
    bit          wr;
    logic [AW-1:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          awd, wd, bd, ard, rd, rspd;
    bit          early_b;
    logic [31:0] rdat;
    logic [1:0]  rr, br;
  } cmd_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_ready;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic          arvalid, arready, rvalid, rready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;

  axi_lite_master #(.C_M_AXI_ADDR_WIDTH(AW)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  cmd_t cmd_q[$];
  cmd_t cur;
  bit   m_busy, m_wr, m_aw, m_w, m_b, m_b_done, m_ar, m_r, m_rsp;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata, m_rdata;
  logic [3:0]    m_wstrb;
  logic [1:0]    m_resp;
  int   m_edges, cycle;
  int   aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, rsp_cnt;
  bit   bv_hold, rv_hold;
  int   rsp_count, rsp_cycle, accept_count, accept_cycle, dut_b_hs;
  logic [31:0] last_rdata;
  logic [1:0]  last_resp;

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    cmd_q.delete();
    {m_busy, m_wr, m_aw, m_w, m_b, m_b_done, m_ar, m_r, m_rsp} = '0;
    m_edges = 0;
    bv_hold = 0; rv_hold = 0;
    bvalid = 0; rvalid = 0;
  endtask

  // Compare every DUT output with what the model says must be there now.
  task automatic checkOutput();
    checkEq("cmd_ready", cmd_ready, (m_edges >= 1) && !m_busy);
    checkEq("awvalid", awvalid, m_aw);
    checkEq("wvalid", wvalid, m_w);
    checkEq("bready", bready, m_b);
    checkEq("arvalid", arvalid, m_ar);
    checkEq("rready", rready, m_r);
    checkEq("rsp_valid", rsp_valid, m_rsp);
    checkEq("awprot", awprot, 0);
    checkEq("arprot", arprot, 0);
    if (m_aw) checkEq("awaddr", awaddr, m_addr);
    if (m_w) begin
      checkEq("wdata", wdata, m_wdata);
      checkEq("wstrb", wstrb, m_wstrb);
    end
    if (m_ar) checkEq("araddr", araddr, m_addr);
    if (m_rsp) begin
      checkEq("rsp_rdata", rsp_rdata, m_rdata);
      checkEq("rsp_resp", rsp_resp, m_resp);
    end
  endtask

  // Drive command source, AXI slave and response consumer for the next edge.
  task automatic applyStimulus();
    if (cmd_q.size() > 0) begin
      cmd_valid = 1'b1;
      cmd_write = cmd_q[0].wr;
      cmd_addr  = cmd_q[0].addr;
      cmd_wdata = cmd_q[0].wdata;
      cmd_wstrb = cmd_q[0].wstrb;
    end else begin
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_wdata = $urandom;
      cmd_wstrb = 4'($urandom);
    end
    awready = m_aw ? (aw_cnt >= cur.awd) : 1'($urandom_range(0, 1));
    wready  = m_w  ? (w_cnt  >= cur.wd)  : 1'($urandom_range(0, 1));
    arready = m_ar ? (ar_cnt >= cur.ard) : 1'($urandom_range(0, 1));
    if (m_aw) aw_cnt++;
    if (m_w) w_cnt++;
    if (m_ar) ar_cnt++;
    if (m_busy && m_wr && !m_b_done && (cur.early_b || (!m_aw && !m_w))) begin
      if (!bv_hold && b_cnt >= cur.bd) begin
        bv_hold = 1;
        bresp = cur.br;
      end
      b_cnt++;
    end
    bvalid = bv_hold;
    if (!bv_hold) bresp = 2'($urandom);
    if (m_r) begin
      if (!rv_hold && r_cnt >= cur.rd) begin
        rv_hold = 1;
        rdata = cur.rdat;
        rresp = cur.rr;
      end
      r_cnt++;
    end
    rvalid = rv_hold;
    if (!rv_hold) begin
      rdata = $urandom;
      rresp = 2'($urandom);
    end
    rsp_ready = m_rsp ? (rsp_cnt >= cur.rspd) : 1'($urandom_range(0, 1));
    if (m_rsp) rsp_cnt++;
  endtask

  // Advance the model across the coming rising edge.
  task automatic updateModel();
    bit cr;
    if (!rst_n) return;
    cr = (m_edges >= 1) && !m_busy;
    m_edges++;
    cycle++;
    if (bready && bvalid) dut_b_hs++;
    if (m_rsp && rsp_ready) begin
      last_rdata = rsp_rdata;
      last_resp  = rsp_resp;
      rsp_count++;
      rsp_cycle = cycle;
      m_rsp = 0;
      m_busy = 0;
    end else if (m_b && bvalid) begin
      m_b = 0; m_b_done = 1; bv_hold = 0;
      m_rsp = 1; m_rdata = 0; m_resp = bresp; rsp_cnt = 0;
    end else if (m_r && rvalid) begin
      m_r = 0; rv_hold = 0;
      m_rsp = 1; m_rdata = rdata; m_resp = rresp; rsp_cnt = 0;
    end
    if (cmd_valid && cr) begin
      cur = cmd_q.pop_front();
      m_busy = 1; m_wr = cur.wr; m_b_done = 0;
      m_addr = cur.addr; m_wdata = cur.wdata; m_wstrb = cur.wstrb;
      m_aw = cur.wr; m_w = cur.wr; m_ar = !cur.wr;
      {aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt} = '0;
      bv_hold = 0; rv_hold = 0;
      accept_count++;
      accept_cycle = cycle;
    end else begin
      if (m_aw && awready) m_aw = 0;
      if (m_w && wready) m_w = 0;
      if (m_ar && arready) begin
        m_ar = 0;
        m_r = 1;
      end
      if (m_busy && m_wr && !m_aw && !m_w && !m_b && !m_b_done) m_b = 1;
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkOutput();
    applyStimulus();
    updateModel();
  endtask

  task automatic waitRsp(input int target);
    for (int i = 0; i < 400 && rsp_count < target; i++) stepCycle();
    checkEq("rsp_wait", rsp_count, target);
  endtask

  task automatic pushCmd(input bit wr, input logic [AW-1:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int awd, input int wd, input int bd,
                         input int ard, input int rd, input int rspd, input bit early_b,
                         input logic [31:0] rdat, input logic [1:0] rr, input logic [1:0] br);
    cmd_t c;
    c.wr = wr; c.addr = a; c.wdata = d; c.wstrb = s;
    c.awd = awd; c.wd = wd; c.bd = bd; c.ard = ard; c.rd = rd; c.rspd = rspd;
    c.early_b = early_b; c.rdat = rdat; c.rr = rr; c.br = br;
    cmd_q.push_back(c);
  endtask

  task automatic releaseReset();
    repeat (2) stepCycle();
    rst_n = 1'b1;
    updateModel();
  endtask

  initial begin
    int base, acc_base, r1, b_base;
    rst_n = 1'b0;
    cycle = 0; rsp_count = 0; accept_count = 0; dut_b_hs = 0;
    awready = 0; wready = 0; arready = 0; rsp_ready = 0;
    bresp = 0; rresp = 0; rdata = 0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    resetModel();
    #1;
    checkEq("reset_cmd_ready", cmd_ready, 0);
    checkEq("reset_rsp_valid", rsp_valid, 0);
    checkEq("reset_awaddr", awaddr, 0);
    checkEq("reset_rsp_rdata", rsp_rdata, 0);
    releaseReset();
    stepCycle();
    checkEq("cmd_ready_after_reset", cmd_ready, 1);

    // Zero-wait write
    base = rsp_count;
    pushCmd(1, 4'h4, 32'hA5A5_0001, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    stepCycle();
    stepCycle();
    checkEq("w0_awvalid", awvalid, 1);
    checkEq("w0_awaddr", awaddr, 32'h4);
    checkEq("w0_wdata", wdata, 32'hA5A5_0001);
    waitRsp(base + 1);
    checkEq("w0_rdata", last_rdata, 0);
    checkEq("w0_resp", last_resp, 0);
    checkEq("w0_latency", rsp_cycle - accept_cycle, 3);

    // Skewed readies with early BVALID
    base = rsp_count;
    b_base = dut_b_hs;
    pushCmd(1, 4'h8, 32'h1234_5678, 4'h3, 3, 0, 0, 0, 0, 0, 1, 0, 0, 2'b01);
    waitRsp(base + 1);
    checkEq("skew_latency", rsp_cycle - accept_cycle, 6);
    checkEq("skew_b_handshakes", dut_b_hs - b_base, 1);
    checkEq("skew_resp", last_resp, 2'b01);

    // Read with a slow ARREADY
    base = rsp_count;
    pushCmd(0, 4'hC, 0, 0, 0, 0, 0, 5, 0, 0, 0, 32'h0000_01FF, 2'b00, 0);
    waitRsp(base + 1);
    checkEq("rd_rdata", last_rdata, 32'h0000_01FF);
    checkEq("rd_resp", last_resp, 0);
    checkEq("rd_latency", rsp_cycle - accept_cycle, 8);

    // Response back-pressure with the next command already waiting
    base = rsp_count;
    acc_base = accept_count;
    pushCmd(0, 4'h2, 0, 0, 0, 0, 0, 1, 2, 4, 0, 32'hDEAD_BEEF, 2'b00, 0);
    pushCmd(1, 4'h6, 32'h0BAD_F00D, 4'hA, 1, 2, 0, 0, 0, 0, 0, 0, 0, 2'b00);
    waitRsp(base + 1);
    r1 = rsp_cycle;
    checkEq("bp_rdata", last_rdata, 32'hDEAD_BEEF);
    for (int i = 0; i < 20 && accept_count < acc_base + 2; i++) stepCycle();
    checkEq("bp_next_accept", accept_cycle - r1, 1);
    waitRsp(base + 2);

    // Read with SLVERR
    base = rsp_count;
    pushCmd(0, 4'h1, 0, 0, 0, 0, 0, 1, 3, 1, 0, 32'h0000_0042, 2'b10, 0);
    waitRsp(base + 1);
    checkEq("err_resp", last_resp, 2'b10);

    // Reset asserted while the write request is outstanding
    base = rsp_count;
    pushCmd(1, 4'hF, 32'hFFFF_0000, 4'hF, 20, 20, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) stepCycle();
    checkEq("pre_reset_awvalid", awvalid, 1);
    rst_n = 1'b0;
    #1;
    checkEq("rst_awvalid", awvalid, 0);
    checkEq("rst_wvalid", wvalid, 0);
    checkEq("rst_cmd_ready", cmd_ready, 0);
    checkEq("rst_wdata", wdata, 0);
    resetModel();
    releaseReset();
    repeat (4) stepCycle();
    checkEq("post_rst_cmd_ready", cmd_ready, 1);
    checkEq("post_rst_no_rsp", rsp_count, base);

    // Randomised traffic
    for (int n = 0; n < 40; n++) begin
      base = rsp_count + ((m_busy) ? 1 : 0);
      pushCmd(1'($urandom), AW'($urandom), $urandom, 4'($urandom),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
              1'($urandom), $urandom, 2'($urandom), 2'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        pushCmd(1'($urandom), AW'($urandom), $urandom, 4'($urandom),
                $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                1'($urandom), $urandom, 2'($urandom), 2'($urandom));
        waitRsp(base + 2);
      end else begin
        waitRsp(base + 1);
      end
      repeat ($urandom_range(0, 3)) stepCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
